perst_seq: RTL

Parametrised PCIe PERST# generator for the core CPLD reset block, driving `NUM_CH` slot/device reset outputs from PCH PLTRST# and CPU power-good. Each channel is strap-selected between a debounced PLTRST# source and a delayed CPUPWRGD source. Releases are staggered in channel-index order to limit inrush. Any loss of source or a forced reset re-asserts the affected channel at once.

---
 rtl/perst_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/perst_seq.sv
// perst_seq: PCIe PERST# generator for the core CPLD reset block.
// Each channel releases from either the debounced PLTRST# or a timed CPU
// power-good, releases are staggered in index order, and any loss of a
// channel's source re-asserts that channel on the following clock.
module perst_seq #(
  parameter int NUM_CH    = 4,
  parameter int PWRGD_DLY = 1300000,
  parameter int STAGGER   = 2000,
  parameter int FILT      = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iPltRst_n,
  input  logic              iCpuPwrgd,
  input  logic [NUM_CH-1:0] iModeSel,
  input  logic [NUM_CH-1:0] iForceRst,
  output logic [NUM_CH-1:0] oPerst_n,
  output logic              oPltRstBuf_n,
  output logic              oAllReleased
);

  localparam int PWR_W = $clog2(PWRGD_DLY + 1);
  localparam int GAP_W = $clog2(STAGGER + 1);
  localparam int FLT_W = $clog2(FILT + 1);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_GAP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic              plt_s1_q, plt_s1_d, plt_s2_q, plt_s2_d;
  logic              pwr_s1_q, pwr_s1_d, pwr_s2_q, pwr_s2_d;
  logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
  logic              flt_lvl_q, flt_lvl_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [NUM_CH-1:0] mode_lat_q, mode_lat_d;
  logic [NUM_CH-1:0] perst_q, perst_d;
  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              all_rel_q, all_rel_d;

  logic              pwr_done;
  logic [NUM_CH-1:0] ok;
  logic              drop;

  // Index of the lowest channel still held in reset (0 when none is).
  function automatic logic [PTR_W-1:0] lowest_zero(input logic [NUM_CH-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!v[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  // Synchronisers, PLTRST# debounce filter, power-good timer and strap latch.
  always_comb begin
    plt_s1_d  = iPltRst_n;
    plt_s2_d  = plt_s1_q;
    pwr_s1_d  = iCpuPwrgd;
    pwr_s2_d  = pwr_s1_q;
    flt_cnt_d = '0;
    flt_lvl_d = 1'b0;
    pwr_cnt_d = '0;
    if (plt_s2_q) begin
      flt_cnt_d = flt_cnt_q;
      if (flt_cnt_q != FLT_W'(FILT)) flt_cnt_d = flt_cnt_q + FLT_W'(1);
      flt_lvl_d = flt_lvl_q | (flt_cnt_q == FLT_W'(FILT));
    end
    if (pwr_s2_q) begin
      pwr_cnt_d = pwr_cnt_q;
      if (pwr_cnt_q != PWR_W'(PWRGD_DLY)) pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
    end
    // Straps track the pins only while the block is held in reset.
    mode_lat_d = iRst_n ? mode_lat_q : iModeSel;
  end

  // The synced level gates the source directly so a falling PLTRST# or
  // PWRGD pulls PERST# low one cycle ahead of the filter/timer clearing.
  assign pwr_done = (pwr_cnt_q == PWR_W'(PWRGD_DLY));

  // Release sequencer: per-channel ok, immediate re-assert, staggered release.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ok[i] = (mode_lat_q[i] ? (pwr_done & pwr_s2_q) : (flt_lvl_q & plt_s2_q))
              & ~iForceRst[i];
    end
    drop    = |(perst_q & ~ok);
    perst_d = perst_q & ok;
    state_d = state_q;
    gap_d   = gap_q;
    if (drop) begin
      state_d = ST_HOLD;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (ok[ptr_q]) begin
            perst_d[ptr_q] = 1'b1;
            if (&perst_d) begin
              state_d = ST_DONE;
            end else begin
              gap_d   = GAP_W'(STAGGER);
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_d == '0) state_d = ST_HOLD;
        end
        ST_DONE: ;
        default: state_d = ST_HOLD;
      endcase
    end
    ptr_d     = lowest_zero(perst_d);
    all_rel_d = (state_d == ST_DONE);
  end

  // State register; everything except the strap latch clears in reset.
  always_ff @(posedge iClk) begin
    mode_lat_q <= mode_lat_d;
    if (!iRst_n) begin
      plt_s1_q  <= 1'b0;
      plt_s2_q  <= 1'b0;
      pwr_s1_q  <= 1'b0;
      pwr_s2_q  <= 1'b0;
      flt_cnt_q <= '0;
      flt_lvl_q <= 1'b0;
      pwr_cnt_q <= '0;
      perst_q   <= '0;
      state_q   <= ST_HOLD;
      ptr_q     <= '0;
      gap_q     <= '0;
      all_rel_q <= 1'b0;
    end else begin
      plt_s1_q  <= plt_s1_d;
      plt_s2_q  <= plt_s2_d;
      pwr_s1_q  <= pwr_s1_d;
      pwr_s2_q  <= pwr_s2_d;
      flt_cnt_q <= flt_cnt_d;
      flt_lvl_q <= flt_lvl_d;
      pwr_cnt_q <= pwr_cnt_d;
      perst_q   <= perst_d;
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign oPerst_n     = perst_q;
  assign oPltRstBuf_n = flt_lvl_q;
  assign oAllReleased = all_rel_q;

endmodule
